// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares a single-port, word-addressed data memory
// between a CPU port (0) and a DMA/debug port (1); one access in flight at a time.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_we_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              rsp_valid_0,
    input  logic              rsp_ready_0,
    output logic [DATA_W-1:0] rsp_rdata_0,
    output logic              rsp_err_0,

    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_1,
    input  logic              rsp_ready_1,
    output logic [DATA_W-1:0] rsp_rdata_1,
    output logic              rsp_err_1,

    output logic [ADDR_W-1:0] mem_readaddr,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_nx;

    logic              last_grant;
    logic              owner;
    logic              lat_we;
    logic              lat_err;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              gnt_valid;
    logic              gnt_port;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;
    logic              rsp_ready_sel;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        gnt_valid     = 1'b0;
        gnt_port      = 1'b0;
        accept        = 1'b0;
        state_nx      = state;
        rsp_ready_sel = owner ? rsp_ready_1 : rsp_ready_0;

        gnt_valid = req_valid_0 | req_valid_1;
        if (req_valid_0 && req_valid_1) begin
            gnt_port = ~last_grant;
        end else begin
            gnt_port = req_valid_1;
        end

        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    accept   = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                state_nx = RESP;
            end
            RESP: begin
                // The consuming cycle returns to IDLE without granting again.
                if (rsp_ready_sel) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign sel_we       = gnt_port ? req_we_1    : req_we_0;
    assign sel_addr     = gnt_port ? req_addr_1  : req_addr_0;
    assign sel_wdata    = gnt_port ? req_wdata_1 : req_wdata_0;
    assign sel_in_range = (sel_addr < ADDR_W'(DEPTH));

    assign req_ready_0 = rst_n && (state == IDLE) && gnt_valid && !gnt_port;
    assign req_ready_1 = rst_n && (state == IDLE) && gnt_valid &&  gnt_port;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            lat_we       <= 1'b0;
            lat_err      <= 1'b0;
            rsp_rdata_q  <= '0;
            mem_readaddr <= '0;
            mem_wen      <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant   <= gnt_port;
                        owner        <= gnt_port;
                        lat_we       <= sel_we;
                        lat_err      <= !sel_in_range;
                        mem_readaddr <= sel_addr;
                        mem_waddr    <= sel_addr;
                        mem_wdata    <= sel_wdata;
                        mem_wen      <= sel_we && sel_in_range;
                    end
                end
                ACCESS: begin
                    mem_wen     <= 1'b0;
                    rsp_rdata_q <= (!lat_we && !lat_err) ? mem_rdata : '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Response outputs are only visible to the owning port while in RESP.
    assign rsp_valid_0 = (state == RESP) && !owner;
    assign rsp_valid_1 = (state == RESP) &&  owner;
    assign rsp_rdata_0 = rsp_valid_0 ? rsp_rdata_q : '0;
    assign rsp_rdata_1 = rsp_valid_1 ? rsp_rdata_q : '0;
    assign rsp_err_0   = rsp_valid_0 && lat_err;
    assign rsp_err_1   = rsp_valid_1 && lat_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural memory plus monitors that record
// accept edges, grant order and write-enable activity.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_valid_0, req_ready_0, req_we_0;
    logic [31:0] req_addr_0, req_wdata_0;
    logic        rsp_valid_0, rsp_ready_0, rsp_err_0;
    logic [31:0] rsp_rdata_0;
    logic        req_valid_1, req_ready_1, req_we_1;
    logic [31:0] req_addr_1, req_wdata_1;
    logic        rsp_valid_1, rsp_ready_1, rsp_err_1;
    logic [31:0] rsp_rdata_1;
    logic [31:0] mem_readaddr, mem_waddr, mem_wdata, mem_rdata;
    logic        mem_wen;

    logic [31:0] dmem [256];
    logic        preload_en;
    int          cyc      = 0;
    int          last_acc = 0;
    int          wen_cnt  = 0;
    int          wen_edge = 0;
    logic [31:0] wen_addr = '0;
    int          gnt_q[$];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .rsp_rdata_0(rsp_rdata_0), .rsp_err_0(rsp_err_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .rsp_rdata_1(rsp_rdata_1), .rsp_err_1(rsp_err_1),
        .mem_readaddr(mem_readaddr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_readaddr < 32'd256) ? dmem[mem_readaddr[7:0]] : '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid_0 && req_ready_0) begin
            last_acc <= cyc + 1;
            gnt_q.push_back(0);
        end
        if (req_valid_1 && req_ready_1) begin
            last_acc <= cyc + 1;
            gnt_q.push_back(1);
        end
        if (preload_en) begin
            for (int i = 0; i < 256; i++) dmem[i] <= i;
        end else if (mem_wen) begin
            wen_cnt  <= wen_cnt + 1;
            wen_edge <= cyc + 1;
            wen_addr <= mem_waddr;
            dmem[mem_waddr[7:0]] <= mem_wdata;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req_valid_0 = v; req_we_0 = we; req_addr_0 = a; req_wdata_0 = d;
        end else begin
            req_valid_1 = v; req_we_1 = we; req_addr_1 = a; req_wdata_1 = d;
        end
    endtask

    // Returns on the falling edge after the accepting rising edge.
    task automatic wait_accept(input int p, input string tag);
        logic ok;
        ok = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if ((p == 0) ? req_ready_0 : req_ready_1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
            #1;
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_rsp(input int p, input string tag,
                            output logic [31:0] rd, output logic er);
        logic ok;
        ok = 1'b0;
        rd = '0;
        er = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((p == 0) ? rsp_valid_0 : rsp_valid_1) begin
                ok = 1'b1;
                rd = (p == 0) ? rsp_rdata_0 : rsp_rdata_1;
                er = (p == 0) ? rsp_err_0 : rsp_err_1;
                break;
            end
            @(negedge clk);
        end
        check(tag, ok, 1);
    endtask

    task automatic txn(input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input string tag,
                       output logic [31:0] rd, output logic er,
                       output int ae, output int re);
        @(negedge clk);
        drive(p, 1'b1, we, a, d);
        wait_accept(p, {tag, "_acc"});
        ae = last_acc;
        drive(p, 1'b0, we, a, d);
        wait_rsp(p, {tag, "_rsp"}, rd, er);
        re = cyc;
    endtask

    logic [31:0] rd;
    logic        er;
    int          ae, re, w0, g0, nresp, nstray;
    int          acc[4];

    initial begin
        rst_n = 1'b0;
        preload_en = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        rsp_ready_0 = 1'b1;
        rsp_ready_1 = 1'b1;
        repeat (2) @(posedge clk);
        preload_en = 1'b0;
        @(negedge clk);

        check("rst_flags", {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
                            rsp_err_0, rsp_err_1, mem_wen}, 0);
        check("rst_rdata", {rsp_rdata_0, rsp_rdata_1}, 0);
        check("rst_maddr", {mem_readaddr, mem_waddr}, 0);
        check("rst_mwdata", mem_wdata, 0);
        rst_n = 1'b1;

        // Single write then read on port 0.
        w0 = wen_cnt;
        txn(0, 1'b1, 32'd5, 32'hDEADBEEF, "wr5", rd, er, ae, re);
        check("wr5_latency", re - ae, 1);
        check("wr5_err", er, 0);
        check("wr5_rdata", rd, 0);
        check("wr5_wen_cycles", wen_cnt - w0, 1);
        check("wr5_wen_edge", wen_edge - ae, 1);
        check("wr5_waddr", wen_addr, 5);
        check("wr5_mem", dmem[5], 32'hDEADBEEF);
        txn(0, 1'b0, 32'd5, 32'h0, "rd5", rd, er, ae, re);
        check("rd5_rdata", rd, 32'hDEADBEEF);
        check("rd5_err", er, 0);

        // Out-of-range write on port 1 must not touch memory (index 0 on wrap).
        w0 = wen_cnt;
        txn(1, 1'b1, 32'd256, 32'hBAD0BAD0, "oor", rd, er, ae, re);
        check("oor_err", er, 1);
        check("oor_rdata", rd, 0);
        check("oor_no_wen", wen_cnt - w0, 0);
        txn(0, 1'b0, 32'd0, 32'h0, "rd0", rd, er, ae, re);
        check("rd0_rdata", rd, 0);
        check("rd0_err", er, 0);
        txn(1, 1'b0, 32'd1, 32'h0, "rd1", rd, er, ae, re);
        check("rd1_rdata", rd, 1);

        // Both ports hold reads: grants must alternate starting with port 0.
        @(negedge clk);
        g0 = gnt_q.size();
        nresp = 0;
        drive(0, 1'b1, 1'b0, 32'd3, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd7, 32'h0);
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid_0) begin
                check("rr_rdata0", rsp_rdata_0, 3);
                nresp++;
            end
            if (rsp_valid_1) begin
                check("rr_rdata1", rsp_rdata_1, 7);
                nresp++;
            end
            if (nresp >= 8) break;
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 32'd3, 32'h0);
        drive(1, 1'b0, 1'b0, 32'd7, 32'h0);
        check("rr_nresp", nresp, 8);
        check("rr_ngrant", gnt_q.size() - g0, 8);
        for (int i = 0; i < 8; i++) begin
            if (g0 + i < gnt_q.size()) check("rr_order", gnt_q[g0 + i], i % 2);
        end

        // Response backpressure on port 1 blocks port 0.
        @(negedge clk);
        @(negedge clk);
        rsp_ready_1 = 1'b0;
        drive(1, 1'b1, 1'b0, 32'd5, 32'h0);
        wait_accept(1, "bp_acc1");
        drive(1, 1'b0, 1'b0, 32'd5, 32'h0);
        drive(0, 1'b1, 1'b0, 32'd3, 32'h0);
        g0 = gnt_q.size();
        wait_rsp(1, "bp_rsp1", rd, er);
        check("bp_rdata1", rd, 32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_hold", {rsp_valid_1, rsp_rdata_1, req_ready_0, rsp_valid_0},
                  {1'b1, 32'hDEADBEEF, 1'b0, 1'b0});
            @(negedge clk);
        end
        rsp_ready_1 = 1'b1;
        wait_accept(0, "bp_acc0");
        drive(0, 1'b0, 1'b0, 32'd3, 32'h0);
        check("bp_ngrant", gnt_q.size() - g0, 1);
        if (gnt_q.size() > g0) check("bp_grant0", gnt_q[g0], 0);
        wait_rsp(0, "bp_rsp0", rd, er);
        check("bp_rdata0", rd, 3);

        // Reset asserted during the ACCESS cycle of a write to address 9.
        @(negedge clk);
        w0 = wen_cnt;
        drive(0, 1'b1, 1'b1, 32'd9, 32'h0000_0099);
        wait_accept(0, "mr_acc");
        check("mr_wen_pre", mem_wen, 1);
        #1;
        drive(0, 1'b0, 1'b1, 32'd9, 32'h0000_0099);
        rst_n = 1'b0;
        #1;
        check("mr_flags", {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
                           rsp_err_0, rsp_err_1, mem_wen}, 0);
        check("mr_rdata", {rsp_rdata_0, rsp_rdata_1}, 0);
        check("mr_maddr", {mem_readaddr, mem_waddr}, 0);
        check("mr_mwdata", mem_wdata, 0);
        @(negedge clk);
        @(negedge clk);
        check("mr_mem9", dmem[9], 9);
        check("mr_no_wen", wen_cnt - w0, 0);
        rst_n = 1'b1;
        nstray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid_0 || rsp_valid_1) nstray++;
        end
        check("mr_no_rsp", nstray, 0);

        // Back-to-back writes on port 0 with rsp_ready high: 3-cycle spacing.
        for (int i = 0; i < 4; i++) begin
            txn(0, 1'b1, 32'd20 + i, 32'hA000_0000 + i, "tp_wr", rd, er, ae, re);
            acc[i] = ae;
            check("tp_wr_err", er, 0);
        end
        for (int i = 1; i < 4; i++) check("tp_gap", acc[i] - acc[i-1], 3);
        for (int i = 0; i < 4; i++) begin
            txn(0, 1'b0, 32'd20 + i, 32'h0, "tp_rd", rd, er, ae, re);
            check("tp_rdata", rd, 32'hA000_0000 + i);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
